uart_rx_fsm: RTL and testbench
==============================

// Module: uart_rx_fsm
// PURPOSE
//  Frame-level controller for the UART receiver. Detects the start condition on rx_in, enables and
//  follows the edge/bit counter, strobes the sampler, deserializer and start/parity/stop checkers at
//  the correct bit boundaries, and issues a one-cycle data_valid for each error-free frame.
//  Sits between the raw serial input and the RX datapath; it holds no data itself.
// PARAMETERS
//  DATA_WIDTH   8   data bits per frame (LSB first); bit_cnt index of last data bit
//  PRESCALE_W   6   width of Prescale; legal values 4, 8, 16, 32
// PORTS
//  clk          in   1            oversampling clock
//  rst          in   1            asynchronous, active-low reset
//  rx_in        in   1            serial line, idle high
//  PAR_EN       in   1            1 = parity bit present after data
//  Prescale     in   PRESCALE_W   oversampling ratio; stable while busy=1
//  edge_cnt     in   5            edge counter value (0..Prescale-1)
//  bit_cnt      in   4            bit counter value (0 = start bit)
//  strt_glitch  in   1            start checker: sampled start bit was 1
//  par_err      in   1            parity checker result, valid while par_chk_en=1
//  stp_err      in   1            stop checker result, valid while stp_chk_en=1
//  cnt_en       out  1            enable to edge/bit counter; low clears it
//  dat_samp_en  out  1            enable to majority sampler
//  deser_en     out  1            one-cycle shift strobe to deserializer
//  strt_chk_en  out  1            one-cycle start-check strobe
//  par_chk_en   out  1            one-cycle parity-check strobe
//  stp_chk_en   out  1            one-cycle stop-check strobe
//  data_valid   out  1            one-cycle pulse: deserializer holds a good frame
//  busy         out  1            1 whenever state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; par_err latch cleared. Reset mid-frame aborts immediately.
//  - Legal Prescale check: in IDLE, Prescale not in {4,8,16,32} -> stay IDLE, ignore rx_in.
//  - last_edge = cnt_en && (edge_cnt == Prescale-1). PAR_EN latched on IDLE->START; the latched copy
//    governs the whole frame.
//  - States (Moore outputs from registered state; strobes = state-qualified last_edge):
//    IDLE : cnt_en=0. rx_in==0 (and legal Prescale) -> START.
//    START: cnt_en=dat_samp_en=1; strt_chk_en=last_edge. At last_edge: strt_glitch -> IDLE,
//           else -> DATA.
//    DATA : deser_en=last_edge. At last_edge with bit_cnt==DATA_WIDTH -> PARITY if PAR_EN else STOP.
//    PARITY: par_chk_en=last_edge; at last_edge latch par_err, -> STOP (no early abort).
//    STOP : stp_chk_en=last_edge. At last_edge: stp_err or latched par_err -> IDLE, else -> VALID.
//    VALID: data_valid=1 for exactly one cycle, cnt_en=0; -> IDLE unconditionally.
//  - cnt_en drops for >=1 cycle between frames, so the counter always restarts at bit_cnt=0.
//    Back-to-back frames lose at most 2 clk of the next start bit.
//  - Frame length in clk from entering START to data_valid: Prescale*(DATA_WIDTH+2+PAR_EN)+0 cycles,
//    data_valid asserted the cycle after STOP's last_edge.
//  - rx_in returning high during START before last_edge is not acted on; only strt_glitch decides.
//  - Inputs strt_glitch/par_err/stp_err are sampled only on their strobe cycle; ignored otherwise.
// CONFIGURATION
//  UART_RX_ERR_STATUS_EN defined: adds outputs par_err_o, frame_err_o (1 bit each, reset 0); on STOP
//    last_edge with a failing frame they pulse one cycle (par_err_o = latched par_err,
//    frame_err_o = stp_err); both may pulse together. Good frames never pulse them.
//  Not defined: ports absent; failing frames are dropped silently; all other behaviour identical.
// TESTING
//  1. Prescale=8, PAR_EN=0, send 0xA5 with good stop -> 8 deser_en pulses, data_valid one cycle,
//     80 clk after START entry.
//  2. Prescale=16, PAR_EN=1, send 0x3C, par_err=0, stp_err=0 -> par_chk_en once at bit 9, data_valid.
//  3. Prescale=8, 1-edge low glitch, strt_glitch=1 at start strobe -> back to IDLE, no deser_en,
//     no data_valid, cnt_en=0.
//  4. PAR_EN=1, par_err=1 -> FSM still reaches STOP, no data_valid; with UART_RX_ERR_STATUS_EN
//     par_err_o pulses once.
//  5. stp_err=1 on frame N, good frame N+1 back-to-back -> frame N dropped, frame N+1 data_valid.
//  6. Prescale=6 or rst low mid-DATA -> FSM IDLE, all outputs 0; after release, next frame received.

Source files
------------

// File: rtl/uart_rx_fsm.sv
// Frame-level controller for the UART receiver.
// Tracks start/data/parity/stop bit boundaries from an external edge/bit counter
// and strobes the sampler, deserializer and checkers. It holds no data itself.
// Optional build macro UART_RX_ERR_STATUS_EN adds registered par_err_o/frame_err_o
// pulses for frames that fail the stop check.
module uart_rx_fsm #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  PAR_EN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic [4:0]            edge_cnt,
    input  logic [3:0]            bit_cnt,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic                  cnt_en,
    output logic                  dat_samp_en,
    output logic                  deser_en,
    output logic                  strt_chk_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  data_valid,
    output logic                  busy
`ifdef UART_RX_ERR_STATUS_EN
    ,
    output logic                  par_err_o,
    output logic                  frame_err_o
`endif
);

    // Common width for comparing the 5-bit edge counter against Prescale-1
    localparam int unsigned CMP_W = (PRESCALE_W > 5) ? PRESCALE_W : 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        VALID  = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic               par_en_q, par_en_d;
    logic               par_err_q, par_err_d;
    logic               prescale_ok_c;
    logic               counting_c;
    logic               last_edge_c;
    logic [CMP_W-1:0]   prescale_m1_c;
`ifdef UART_RX_ERR_STATUS_EN
    logic               par_err_o_q, par_err_o_d;
    logic               frame_err_o_q, frame_err_o_d;
`endif

    // Frame state, latched parity mode and latched parity result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            par_en_q  <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            par_en_q  <= par_en_d;
            par_err_q <= par_err_d;
        end
    end

`ifdef UART_RX_ERR_STATUS_EN
    // Error status pulses, one cycle after the failing stop check
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_err_o_q   <= 1'b0;
            frame_err_o_q <= 1'b0;
        end else begin
            par_err_o_q   <= par_err_o_d;
            frame_err_o_q <= frame_err_o_d;
        end
    end

    assign par_err_o   = par_err_o_q;
    assign frame_err_o = frame_err_o_q;
`endif

    // Next-state and state-decoded outputs; strobes are last_edge qualified by state
    always_comb begin
        state_d       = state_q;
        par_en_d      = par_en_q;
        par_err_d     = par_err_q;
        cnt_en        = 1'b0;
        dat_samp_en   = 1'b0;
        deser_en      = 1'b0;
        strt_chk_en   = 1'b0;
        par_chk_en    = 1'b0;
        stp_chk_en    = 1'b0;
        data_valid    = 1'b0;
        busy          = 1'b0;
`ifdef UART_RX_ERR_STATUS_EN
        par_err_o_d   = 1'b0;
        frame_err_o_d = 1'b0;
`endif

        prescale_ok_c = (Prescale == PRESCALE_W'(4))  ||
                        (Prescale == PRESCALE_W'(8))  ||
                        (Prescale == PRESCALE_W'(16)) ||
                        (Prescale == PRESCALE_W'(32));
        prescale_m1_c = CMP_W'(Prescale) - CMP_W'(1);
        counting_c    = (state_q == START) || (state_q == DATA) ||
                        (state_q == PARITY) || (state_q == STOP);
        last_edge_c   = counting_c && (CMP_W'(edge_cnt) == prescale_m1_c);

        cnt_en        = counting_c;
        dat_samp_en   = counting_c;
        busy          = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                // An illegal Prescale keeps the receiver deaf to the line
                if (!rx_in && prescale_ok_c) begin
                    state_d   = START;
                    par_en_d  = PAR_EN;
                    par_err_d = 1'b0;
                end
            end
            START: begin
                strt_chk_en = last_edge_c;
                if (last_edge_c) begin
                    state_d = strt_glitch ? IDLE : DATA;
                end
            end
            DATA: begin
                deser_en = last_edge_c;
                if (last_edge_c && (bit_cnt == 4'(DATA_WIDTH))) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                par_chk_en = last_edge_c;
                if (last_edge_c) begin
                    par_err_d = par_err;
                    state_d   = STOP;
                end
            end
            STOP: begin
                stp_chk_en = last_edge_c;
                if (last_edge_c) begin
                    if (stp_err || par_err_q) begin
                        state_d = IDLE;
`ifdef UART_RX_ERR_STATUS_EN
                        par_err_o_d   = par_err_q;
                        frame_err_o_d = stp_err;
`endif
                    end else begin
                        state_d = VALID;
                    end
                end
            end
            VALID: begin
                data_valid = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: directed frames followed by random frames,
// compared every cycle against a timeline model of the frame (offset k from START entry).
module tb_uart_rx_fsm;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_in;
    logic          PAR_EN;
    logic [PW-1:0] Prescale;
    logic [4:0]    edge_cnt;
    logic [3:0]    bit_cnt;
    logic          strt_glitch;
    logic          par_err;
    logic          stp_err;
    logic          cnt_en;
    logic          dat_samp_en;
    logic          deser_en;
    logic          strt_chk_en;
    logic          par_chk_en;
    logic          stp_chk_en;
    logic          data_valid;
    logic          busy;
`ifdef UART_RX_ERR_STATUS_EN
    logic          par_err_o;
    logic          frame_err_o;
`endif

    uart_rx_fsm #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .PAR_EN(PAR_EN), .Prescale(Prescale),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .strt_glitch(strt_glitch),
        .par_err(par_err), .stp_err(stp_err), .cnt_en(cnt_en), .dat_samp_en(dat_samp_en),
        .deser_en(deser_en), .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en),
        .stp_chk_en(stp_chk_en), .data_valid(data_valid), .busy(busy)
`ifdef UART_RX_ERR_STATUS_EN
        , .par_err_o(par_err_o), .frame_err_o(frame_err_o)
`endif
    );

    always #5 clk = ~clk;

    // Bookkeeping
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Timeline model: k = cycles since START entry, -1 when idle
    int k     = -1;
    int mp    = 8;
    bit mpar  = 1'b0;
    bit mplat = 1'b0;
    bit fg, fpe, fse;            // strobe answers of the frame in flight
    bit g_pend, pe_pend, se_pend; // strobe answers for the next frame to start
    bit e_par, e_frm;            // expected error-status pulses this cycle

    // Observed event counters
    int n_deser, n_dv, n_par, n_stp, n_strt, n_busy, n_perr, n_ferr;
    int first_busy, dv_cyc, par_bit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input int p);
        return (p == 4) || (p == 8) || (p == 16) || (p == 32);
    endfunction

    function automatic int frame_len();
        return mp * (DW + 2 + int'(mpar));
    endfunction

    function automatic logic [7:0] expect_vec();
        int  s;
        bit  cnt, strt, des, par, stp, dv;
        if (k < 0) return 8'h00;
        s    = frame_len();
        cnt  = (k < s);
        strt = (k == mp - 1);
        des  = (k >= 2 * mp - 1) && (k <= mp * (DW + 1) - 1) && (((k + 1) % mp) == 0);
        par  = mpar && (k == mp * (DW + 2) - 1);
        stp  = (k == s - 1);
        dv   = (k == s);
        return {cnt, cnt, des, strt, par, stp, dv, 1'b1};
    endfunction

    task automatic clr_cnt();
        n_deser = 0; n_dv = 0; n_par = 0; n_stp = 0; n_strt = 0; n_busy = 0;
        n_perr = 0; n_ferr = 0; first_busy = -1; dv_cyc = -1; par_bit = -1;
    endtask

    task automatic model_update();
        int s;
        e_par = 1'b0;
        e_frm = 1'b0;
        if (!rst) begin
            k = -1;
        end else if (k < 0) begin
            if (!rx_in && legal(int'(Prescale))) begin
                k = 0; mp = int'(Prescale); mpar = PAR_EN; mplat = 1'b0;
                fg = g_pend; fpe = pe_pend; fse = se_pend;
            end
        end else begin
            s = frame_len();
            if (k == mp - 1 && strt_glitch) begin
                k = -1;
            end else if (k == s - 1) begin
                if (stp_err || mplat) begin
                    e_par = mplat; e_frm = stp_err; k = -1;
                end else begin
                    k = s;
                end
            end else if (k == s) begin
                k = -1;
            end else begin
                if (mpar && k == mp * (DW + 2) - 1) mplat = par_err;
                k++;
            end
        end
    endtask

    // Counter values and checker answers as the surrounding datapath would present them
    task automatic drive_side();
        int s;
        s = frame_len();
        if (k < 0 || k >= s) begin
            edge_cnt = 5'($urandom);
            bit_cnt  = 4'($urandom);
        end else begin
            edge_cnt = 5'(k % mp);
            bit_cnt  = 4'(k / mp);
        end
        strt_glitch = (k >= 0 && k == mp - 1) ? fg : 1'($urandom);
        par_err     = (k >= 0 && mpar && k == mp * (DW + 2) - 1) ? fpe : 1'($urandom);
        stp_err     = (k >= 0 && k == s - 1) ? fse : 1'($urandom);
    endtask

    task automatic check_outputs();
        logic [7:0] obs;
        obs = {cnt_en, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, busy};
        chk($sformatf("outputs@%0d", cyc), 32'(obs), 32'(expect_vec()));
`ifdef UART_RX_ERR_STATUS_EN
        chk($sformatf("err_status@%0d", cyc), 32'({par_err_o, frame_err_o}), 32'({e_par, e_frm}));
        n_perr += int'(par_err_o);
        n_ferr += int'(frame_err_o);
`endif
        n_deser += int'(deser_en);
        n_dv    += int'(data_valid);
        n_par   += int'(par_chk_en);
        n_stp   += int'(stp_chk_en);
        n_strt  += int'(strt_chk_en);
        n_busy  += int'(busy);
        if (busy && first_busy < 0) first_busy = cyc;
        if (data_valid) dv_cyc = cyc;
        if (par_chk_en) par_bit = int'(bit_cnt);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        cyc++;
        @(negedge clk);
        drive_side();
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) step();
    endtask

    task automatic drain();
        for (int i = 0; i < 600 && k >= 0; i++) step();
        chk("drain_idle", 32'(busy), 32'(0));
    endtask

    task automatic send_frame(input int p, input bit par, input logic [7:0] data,
                              input bit g, input bit pe, input bit se, input int abort_at);
        logic [11:0] bits;
        int          nbits;
        int          n;
        Prescale = PW'(p);
        PAR_EN   = par;
        g_pend = g; pe_pend = pe; se_pend = se;
        nbits = DW + 2 + int'(par);
        bits  = '0;
        for (int i = 0; i < DW; i++) bits[1 + i] = data[i];
        if (par) bits[DW + 1] = ^data;
        bits[nbits - 1] = 1'b1;
        n = 0;
        if (g) begin
            rx_in = 1'b0;
            step();
            rx_in  = 1'b1;
            PAR_EN = 1'($urandom);
            return;
        end
        for (int b = 0; b < nbits; b++) begin
            for (int e = 0; e < p; e++) begin
                if (abort_at != 0 && n >= abort_at) return;
                rx_in = bits[b];
                step();
                n++;
                if (n == 1) PAR_EN = 1'($urandom);
            end
        end
        rx_in = 1'b1;
    endtask

    task automatic apply_reset();
        rst   = 1'b0;
        rx_in = 1'b1;
        #1;
        k = -1; e_par = 1'b0; e_frm = 1'b0; mplat = 1'b0;
        check_outputs();
        @(negedge clk);
        #1;
        check_outputs();
        rst = 1'b1;
    endtask

    initial begin
        int        p, prev_p, gap;
        bit        par, g, pe, se, last_g;
        logic [7:0] d;

        rst = 1'b1; rx_in = 1'b1; PAR_EN = 1'b0; Prescale = PW'(8);
        edge_cnt = '0; bit_cnt = '0; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        g_pend = 0; pe_pend = 0; se_pend = 0; fg = 0; fpe = 0; fse = 0; e_par = 0; e_frm = 0;
        clr_cnt();
        #2 rst = 1'b0;
        #1 check_outputs();
        @(negedge clk);
        #1 rst = 1'b1;
        idle(4);

        // Basic frame, no parity
        clr_cnt();
        send_frame(8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 0);
        drain();
        chk("t1_deser", 32'(n_deser), 32'(8));
        chk("t1_valid", 32'(n_dv), 32'(1));
        chk("t1_latency", 32'(dv_cyc - first_busy), 32'(80));
        idle(3);

        // Parity frame at Prescale 16
        clr_cnt();
        send_frame(16, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 0);
        drain();
        chk("t2_par_strobes", 32'(n_par), 32'(1));
        chk("t2_par_bit", 32'(par_bit), 32'(9));
        chk("t2_valid", 32'(n_dv), 32'(1));
        chk("t2_latency", 32'(dv_cyc - first_busy), 32'(176));
        idle(3);

        // False start: glitch reported at the start strobe
        clr_cnt();
        send_frame(8, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0);
        drain();
        chk("t3_deser", 32'(n_deser), 32'(0));
        chk("t3_valid", 32'(n_dv), 32'(0));
        chk("t3_start_strobes", 32'(n_strt), 32'(1));
        chk("t3_busy_cycles", 32'(n_busy), 32'(8));
        idle(3);

        // Parity error still runs to the stop check, frame dropped
        clr_cnt();
        send_frame(8, 1'b1, 8'h81, 1'b0, 1'b1, 1'b0, 0);
        drain();
        chk("t4_stop_strobes", 32'(n_stp), 32'(1));
        chk("t4_valid", 32'(n_dv), 32'(0));
`ifdef UART_RX_ERR_STATUS_EN
        chk("t4_par_err_o", 32'(n_perr), 32'(1));
        chk("t4_frame_err_o", 32'(n_ferr), 32'(0));
`endif
        idle(3);

        // Stop error then a back-to-back good frame
        clr_cnt();
        send_frame(8, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 0);
        send_frame(8, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 0);
        drain();
        chk("t5_valid", 32'(n_dv), 32'(1));
        chk("t5_deser", 32'(n_deser), 32'(16));
        chk("t5_stop_strobes", 32'(n_stp), 32'(2));
`ifdef UART_RX_ERR_STATUS_EN
        chk("t5_frame_err_o", 32'(n_ferr), 32'(1));
`endif
        idle(3);

        // Illegal Prescale ignores a low line
        clr_cnt();
        Prescale = PW'(6);
        rx_in    = 1'b0;
        repeat (20) step();
        rx_in = 1'b1;
        chk("t6_illegal_busy", 32'(n_busy), 32'(0));
        idle(2);

        // Reset in the middle of the data bits, then a clean frame
        send_frame(8, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 40);
        apply_reset();
        idle(3);
        clr_cnt();
        send_frame(8, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0, 0);
        drain();
        chk("t6_after_reset_valid", 32'(n_dv), 32'(1));
        chk("t6_after_reset_deser", 32'(n_deser), 32'(8));
        idle(3);

        // Random frames, occasionally chained back-to-back
        prev_p = 8;
        last_g = 1'b1;
        for (int f = 0; f < 24; f++) begin
            gap = $urandom_range(0, 3);
            if (gap != 0 || last_g) begin
                drain();
                Prescale = PW'(6);
                for (int i = 0; i < gap; i++) begin
                    rx_in = 1'($urandom);
                    step();
                end
                rx_in = 1'b1;
                case ($urandom_range(0, 3))
                    0:       p = 4;
                    1:       p = 8;
                    2:       p = 16;
                    default: p = 32;
                endcase
            end else begin
                p = prev_p;
            end
            par = 1'($urandom);
            d   = 8'($urandom);
            g   = ($urandom_range(0, 7) == 0);
            pe  = ($urandom_range(0, 3) == 0);
            se  = ($urandom_range(0, 3) == 0);
            send_frame(p, par, d, g, pe, se, 0);
            prev_p = p;
            last_g = g;
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
